// File: rtl/shift_counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_counter_pkg : mode/direction encodings and seed helper       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package shift_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LSB      = 1'b0;
  localparam logic DIR_MSB      = 1'b1;

  // Bit idx of the seed for a counter of the given width: MSB-only in ring mode, zero in Johnson.
  function automatic logic seed_bit(input logic mode, input int idx, input int width);
    return (mode == MODE_RING) && (idx == width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_counter_if : control inputs and registered outputs           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface shift_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] state;
  logic             wrap;
  logic             err;

  modport master (
    output en, mode, dir, load, load_val,
    input  state, wrap, err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output state, wrap, err
  );

endinterface
`default_nettype wire

// File: rtl/shift_counter_next.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_next : next-state, legality and seed detection               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module shift_next
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] next,
  output logic             legal,
  output logic             is_seed
);

  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-2:0] w_trans;
  logic             w_johnson;
  logic             w_legal_ring;
  logic             w_legal_johnson;

  always_comb begin
    w_seed = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_seed[i] = seed_bit(mode, i, WIDTH);
    end
  end

  assign w_johnson = (mode == MODE_JOHNSON);

  // The bit entering the vacated end is inverted in Johnson mode only.
  assign w_shifted = (dir == DIR_MSB)
                   ? {state[WIDTH-2:0], state[WIDTH-1] ^ w_johnson}
                   : {state[0] ^ w_johnson, state[WIDTH-1:1]};

  assign w_trans         = state[WIDTH-1:1] ^ state[WIDTH-2:0];
  assign w_legal_johnson = ((w_trans & (w_trans - (WIDTH-1)'(1))) == '0);
  assign w_legal_ring    = $onehot(state);

  assign legal   = w_johnson ? w_legal_johnson : w_legal_ring;
  assign next    = legal ? w_shifted : w_seed;
  assign is_seed = legal && (w_shifted == w_seed);

endmodule
`default_nettype wire

// File: rtl/shift_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_counter : ring / Johnson counter with load and self-repair   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module shift_counter
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  shift_counter_if.slave  bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("shift_counter: WIDTH must be >= 2");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_next;
  logic             w_legal;
  logic             w_is_seed;

  shift_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .state   (state_q),
    .mode    (bus.mode),
    .dir     (bus.dir),
    .next    (w_next),
    .legal   (w_legal),
    .is_seed (w_is_seed)
  );

  always_comb begin
    w_seed = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_seed[i] = seed_bit(bus.mode, i, WIDTH);
    end
  end

  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      state_d = bus.load_val;
    end else if (bus.en) begin
      state_d = w_next;
      wrap_d  = w_is_seed;
      err_d   = ~w_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= w_seed;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.state = state_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: doc/shift_counter.md
SHIFT_COUNTER -- requirements
Module: shift_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; SHALL be >= 2.
REQ-002 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 Port reset, input, 1; the block uses one clock and a synchronous, active-high reset.
REQ-004 Port en, input, 1; advance one step when high.
REQ-005 Port mode, input, 1; 0 = ring (one-hot rotate), 1 = Johnson (twisted ring).
REQ-006 Port dir, input, 1; 0 = shift toward LSB, 1 = shift toward MSB.
REQ-007 Port load, input, 1; parallel-load request.
REQ-008 Port load_val, input, WIDTH; value written on load.
REQ-009 Port state, output, WIDTH; registered counter value.
REQ-010 Port wrap, output, 1; registered one-cycle pulse when a step lands on the seed.
REQ-011 Port err, output, 1; registered one-cycle pulse when an illegal state is corrected.

Function
REQ-012 Seed SHALL be {1'b1, (WIDTH-1)'b0} in ring mode and all-zeros in Johnson mode.
REQ-013 Per-cycle priority SHALL be reset > load > en > hold.
REQ-014 Ring, dir=0: state <= {state[0], state[WIDTH-1:1]}; WIDTH=4: 1000->0100->0010->0001->1000.
REQ-015 Ring, dir=1: state <= {state[WIDTH-2:0], state[WIDTH-1]}; WIDTH=4: 1000->0001->0010->0100->1000.
REQ-016 Johnson, dir=0: state <= {~state[0], state[WIDTH-1:1]}; WIDTH=4: 0000->1000->1100->1110->1111->0111->0011->0001->0000.
REQ-017 Johnson, dir=1: state <= {state[WIDTH-2:0], ~state[WIDTH-1]}; WIDTH=4: 0000->0001->0011->...->1000->0000.
REQ-018 Ring legal states SHALL be exactly the WIDTH one-hot values; zero or multiple ones is illegal.
REQ-019 Johnson legal states SHALL be the 2*WIDTH values with at most one adjacent-bit transition (bit i vs bit i+1, no wrap).
REQ-020 Enabled step from an illegal state (for the current mode) SHALL load the current mode's seed instead of shifting and pulse err on the following cycle.
REQ-021 load=1 SHALL write load_val unchanged, even if illegal; no err, no wrap on the load cycle.
REQ-022 wrap SHALL be high exactly in the cycle after a legal enabled step whose result equals the seed; correction to seed SHALL NOT raise wrap.
REQ-023 en=0 and load=0 SHALL hold state; wrap and err low.
REQ-024 mode or dir changes SHALL take effect on the next enabled step, with legality judged against the new mode.
REQ-025 wrap and err SHALL never be high in the same cycle.

Reset
REQ-026 reset=1 at a rising edge SHALL set state to the seed of the mode sampled that cycle, wrap=0, err=0.
REQ-027 reset SHALL override simultaneous load and en; mid-sequence reset SHALL restart from the seed on the next edge.
REQ-028 No initial blocks; the power-up value is defined only by reset.

Structure
REQ-029 Package shift_counter_pkg SHALL hold MODE_RING/MODE_JOHNSON and DIR_LSB/DIR_MSB constants and the seed function.
REQ-030 Combinational next-state and legality logic SHALL live in one sub-module, shift_next (inputs state, mode, dir; outputs next, legal, is_seed).
REQ-031 The top SHALL contain only the priority mux and output registers; non-blocking assignments only.

Verification
REQ-032 WIDTH=4, reset, mode=0, dir=0, en=1 for 8 cycles -> state 1000,0100,0010,0001,1000,...; wrap high once per 4 steps.
REQ-033 WIDTH=4, mode=1, dir=1, en=1 for 9 cycles from reset -> 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap after step 8.
REQ-034 mode=0, load 0110, then en=1 -> state 0110, then 1000 with err pulse, wrap low.
REQ-035 mode=1, load 0101, en=1 -> corrected to 0000, err one cycle; load 1100 -> legal, continues 1110.
REQ-036 reset, load and en all high mid-sequence -> state = seed, wrap=0, err=0; en=0 for 3 cycles -> state frozen.
REQ-037 WIDTH=8 ring, dir toggled each step -> state alternates 10000000/00000001; no err.
